// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_pkg
// Description : Shared fetch-stage definitions: FSM state encoding and
//               parameter defaults used by the fetch unit and its PC register.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

  // Fetch sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LOAD = 2'd2
  } fetch_state_t;

  localparam int          DEF_ADDR_WIDTH = 16;
  localparam int          DEF_DATA_WIDTH = 16;
  localparam int          DEF_WAIT_LIMIT = 15;
  localparam logic [15:0] DEF_RESET_PC   = 16'h0000;

endpackage : instruction_fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch_program_counter.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_program_counter
// Description : Program counter register with absolute load and increment.
//               Load takes priority over increment; increment wraps modulo
//               2^ADDR_WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_program_counter #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  notReset,
  input  logic                  load,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] load_value,
  output logic [ADDR_WIDTH-1:0] pc
);

  // PC register: async reset, jump load wins over post-increment
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + ADDR_WIDTH'(1);
    end
  end

endmodule : instruction_fetch_program_counter
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Fetch stage feeding the instruction register. Performs a
//               req/ack memory read at the PC, strobes the word into the IR
//               with a one-cycle active-low load, then post-increments the PC.
//               A read that is not acknowledged within WAIT_LIMIT cycles sets
//               a sticky fault and abandons the fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC),
  parameter int                    WAIT_LIMIT = DEF_WAIT_LIMIT
) (
  input  logic                  clock,
  input  logic                  notReset,
  input  logic                  start,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jumpAddr,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memReq,
  input  logic                  memAck,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic [DATA_WIDTH-1:0] irData,
  output logic                  irNotLoad,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  done,
  output logic                  fault
);

  localparam int                 CNT_W    = $clog2(WAIT_LIMIT + 1);
  // Last REQ cycle index at which a missing ack still counts as "waiting"
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  fetch_state_t     state;
  fetch_state_t     next_state;
  logic [CNT_W-1:0] wait_count;
  logic             pc_load;
  logic             pc_inc;
  logic             accept;
  logic             capture;
  logic             timeout;

  instruction_fetch_program_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clock      (clock),
    .notReset   (notReset),
    .load       (pc_load),
    .inc        (pc_inc),
    .load_value (jumpAddr),
    .pc         (pc)
  );

  // State register; async reset drops memReq immediately mid-fetch
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode; ack is checked before the timeout so an
  // ack on the final allowed cycle is still accepted
  always_comb begin
    next_state = state;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    case (state)
      ST_IDLE: begin
        pc_load = jump;
        if (start) begin
          accept     = 1'b1;
          next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        if (memAck) begin
          capture    = 1'b1;
          next_state = ST_LOAD;
        end else if (wait_count == CNT_LAST) begin
          timeout    = 1'b1;
          next_state = ST_IDLE;
        end
      end
      ST_LOAD: begin
        pc_inc     = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Wait counter, captured instruction word and sticky fault flag
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      wait_count <= '0;
      irData     <= '0;
      fault      <= 1'b0;
    end else begin
      if (accept) begin
        wait_count <= '0;
        fault      <= 1'b0;
      end else if (state == ST_REQ && !memAck && !timeout) begin
        wait_count <= wait_count + CNT_W'(1);
      end
      if (timeout) begin
        fault <= 1'b1;
      end
      if (capture) begin
        irData <= memData;
      end
    end
  end

  // Outputs decoded from registered state only
  assign memAddr   = pc;
  assign memReq    = (state == ST_REQ);
  assign irNotLoad = (state != ST_LOAD);
  assign done      = (state == ST_LOAD);
  assign busy      = (state != ST_IDLE);

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Scoreboard bench for instruction_fetch. A driver issues
//               directed and random fetches, predicting each outcome from a
//               simple PC/ack-latency model; a monitor pops predictions when
//               the DUT strobes the IR or raises fault.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  localparam int          WL  = 15;
  localparam logic [15:0] RPC = 16'h0000;

  logic        clock = 1'b0;
  logic        notReset;
  logic        start;
  logic        jump;
  logic [15:0] jumpAddr;
  logic [15:0] memAddr;
  logic        memReq;
  logic        memAck;
  logic [15:0] memData;
  logic [15:0] irData;
  logic        irNotLoad;
  logic [15:0] pc;
  logic        busy;
  logic        done;
  logic        fault;

  instruction_fetch #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (16),
    .RESET_PC   (RPC),
    .WAIT_LIMIT (WL)
  ) dut (
    .clock     (clock),
    .notReset  (notReset),
    .start     (start),
    .jump      (jump),
    .jumpAddr  (jumpAddr),
    .memAddr   (memAddr),
    .memReq    (memReq),
    .memAck    (memAck),
    .memData   (memData),
    .irData    (irData),
    .irNotLoad (irNotLoad),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .fault     (fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_fault;
    logic [15:0] data;
    logic [15:0] addr;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_pc;
  int          total = 0;
  int          bad   = 0;
  bit          prev_fault = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop a prediction whenever the IR is strobed or fault rises
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (notReset === 1'b1 && done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_load", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("load_kind", 32'(e.is_fault), 32'd0);
          check("ir_data", 32'(irData), 32'(e.data));
          check("ir_not_load", 32'(irNotLoad), 32'd0);
          check("pc_at_load", 32'(pc), 32'(e.addr));
          @(negedge clock);
          check("pc_after_load", 32'(pc), 32'(16'(e.addr + 16'd1)));
          check("done_one_cycle", 32'(done), 32'd0);
          check("ir_hold", 32'(irData), 32'(e.data));
        end
      end
      if (notReset === 1'b1 && fault === 1'b1 && !prev_fault) begin
        if (sb.size() == 0) begin
          check("unexpected_fault", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("fault_kind", 32'(e.is_fault), 32'd1);
          check("fault_mem_req", 32'(memReq), 32'd0);
          check("fault_no_strobe", 32'(irNotLoad), 32'd1);
          check("fault_pc", 32'(pc), 32'(e.addr));
        end
      end
      prev_fault = (fault === 1'b1);
    end
  end

  // One fetch: k = REQ cycle carrying the ack (1..WL), 0 = never ack.
  // noise drives random start/jump while the DUT is busy.
  task automatic do_fetch(input bit j, input logic [15:0] ja, input logic [15:0] d,
                          input int k, input bit noise);
    exp_t        e;
    logic [15:0] fa;
    int          n;
    start    = 1'b1;
    jump     = j;
    jumpAddr = ja;
    memAck   = 1'b0;
    if (j) ref_pc = ja;
    fa         = ref_pc;
    e.addr     = fa;
    e.is_fault = (k == 0);
    e.data     = d;
    if (k != 0) ref_pc = fa + 16'd1;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    jump  = 1'b0;
    check("req_mem_req", 32'(memReq), 32'd1);
    check("req_addr", 32'(memAddr), 32'(fa));
    check("req_fault_clear", 32'(fault), 32'd0);
    for (int c = 1; c <= WL; c++) begin
      if (c == k) begin
        memAck  = 1'b1;
        memData = d;
      end else begin
        memAck  = 1'b0;
        memData = 16'($urandom);
        if (noise) begin
          start    = 1'($urandom);
          jump     = 1'($urandom);
          jumpAddr = 16'($urandom);
        end
      end
      @(negedge clock);
      start  = 1'b0;
      jump   = 1'b0;
      memAck = 1'b0;
      if (c == k) break;
    end
    n = 0;
    while (busy !== 1'b0 && n < 10) begin
      @(negedge clock);
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", 32'(busy), 32'd0);
    // Idle gap with stray acks that must be ignored
    repeat ($urandom_range(0, 2)) begin
      memAck  = 1'($urandom);
      memData = 16'($urandom);
      @(negedge clock);
    end
    memAck = 1'b0;
  endtask

  // Reset in the middle of a REQ phase
  task automatic reset_mid_fetch();
    start    = 1'b1;
    jump     = 1'b1;
    jumpAddr = 16'($urandom);
    @(negedge clock);
    start = 1'b0;
    jump  = 1'b0;
    check("rst_req_before", 32'(memReq), 32'd1);
    #2 notReset = 1'b0;
    #1;
    check("rst_mem_req", 32'(memReq), 32'd0);
    check("rst_pc", 32'(pc), 32'(RPC));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_no_strobe", 32'(irNotLoad), 32'd1);
    @(negedge clock);
    notReset = 1'b1;
    ref_pc   = RPC;
    @(negedge clock);
  endtask

  initial begin : driver
    notReset = 1'b0;
    start    = 1'b0;
    jump     = 1'b0;
    jumpAddr = '0;
    memAck   = 1'b0;
    memData  = '0;
    repeat (2) @(negedge clock);
    check("reset_mem_req", 32'(memReq), 32'd0);
    check("reset_ir_not_load", 32'(irNotLoad), 32'd1);
    check("reset_ir_data", 32'(irData), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_fault", 32'(fault), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pc", 32'(pc), 32'(RPC));
    notReset = 1'b1;
    ref_pc   = RPC;
    @(negedge clock);

    do_fetch(1'b0, 16'h0000, 16'hA5C3, 1, 1'b0);
    do_fetch(1'b1, 16'h0FFF, 16'h1234, 2, 1'b0);
    do_fetch(1'b1, 16'hFFFF, 16'hBEEF, 1, 1'b0);
    check("wrap_pc", 32'(pc), 32'h0000);
    do_fetch(1'b0, 16'h0000, 16'h0000, 0, 1'b0);
    do_fetch(1'b0, 16'h0000, 16'h5A5A, 3, 1'b0);
    do_fetch(1'b0, 16'h0000, 16'hC0DE, WL, 1'b0);
    do_fetch(1'b0, 16'h0000, 16'h7E57, 5, 1'b1);
    reset_mid_fetch();
    check("post_reset_pc", 32'(pc), 32'(RPC));

    for (int i = 0; i < 40; i++) begin
      do_fetch($urandom_range(0, 3) == 0, 16'($urandom), 16'($urandom),
               ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6)),
               1'($urandom));
    end

    repeat (3) @(negedge clock);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("final_pc", 32'(pc), 32'(ref_pc));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_instruction_fetch
`default_nettype wire
